// File: rtl/mesm6_gpio2_pkg.sv
// Shared constants for the mesm6_gpio2 GPIO block: bus widths, register map
// and CTRL bit positions.
package mesm6_gpio2_pkg;
    localparam int DATA_W = 48;
    localparam int ADDR_W = 15;

    localparam logic [3:0] ADDR_DIR   = 4'd0;
    localparam logic [3:0] ADDR_PORT  = 4'd1;
    localparam logic [3:0] ADDR_SET   = 4'd2;
    localparam logic [3:0] ADDR_CLR   = 4'd3;
    localparam logic [3:0] ADDR_TGL   = 4'd4;
    localparam logic [3:0] ADDR_VAL   = 4'd5;
    localparam logic [3:0] ADDR_IEN   = 4'd6;
    localparam logic [3:0] ADDR_IRISE = 4'd7;
    localparam logic [3:0] ADDR_IFALL = 4'd8;
    localparam logic [3:0] ADDR_IFLAG = 4'd9;
    localparam logic [3:0] ADDR_CTRL  = 4'd10;

    localparam int CTRL_GIE = 0;
endpackage

// File: rtl/mesm6_gpio2_if.sv
// CPU-side register bus of the GPIO block.
interface mesm6_gpio2_if;
    import mesm6_gpio2_pkg::*;

    // A request is one cycle with gpio_read and/or gpio_write high (no ready;
    // the slave always accepts). gpio_done pulses the following cycle and
    // gpio_rdata is valid while gpio_done is high.
    logic [ADDR_W-1:0] gpio_addr;
    logic              gpio_read;
    logic              gpio_write;
    logic [DATA_W-1:0] gpio_wdata;
    logic [DATA_W-1:0] gpio_rdata;
    logic              gpio_done;

    modport master (
        output gpio_addr, gpio_read, gpio_write, gpio_wdata,
        input  gpio_rdata, gpio_done
    );
    modport slave (
        input  gpio_addr, gpio_read, gpio_write, gpio_wdata,
        output gpio_rdata, gpio_done
    );
endinterface

// File: rtl/mesm6_gpio2_filter.sv
// Per-pin two-flop synchroniser followed by an optional stability filter.
module mesm6_gpio2_filter #(
    parameter int DEBOUNCE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic val
);
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) val <= 1'b0;
                else       val <= sync2;
            end
        end else begin : g_debounce
            localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
            logic [CW-1:0] count;

            // Count cycles the synchronised input disagrees with val; any
            // agreement restarts the run.
            always_ff @(posedge clk) begin
                if (reset) begin
                    count <= '0;
                    val   <= 1'b0;
                end else if (sync2 == val) begin
                    count <= '0;
                end else if (count == CW'(DEBOUNCE - 1)) begin
                    val   <= sync2;
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    endgenerate
endmodule

// File: rtl/mesm6_gpio2.sv
// GPIO block: direction/port registers, filtered input value, edge-triggered
// interrupt flags and a single-cycle register bus.
module mesm6_gpio2
    import mesm6_gpio2_pkg::*;
#(
    parameter int WIDTH    = 48,
    parameter int DEBOUNCE = 0
) (
    input  logic              clk,
    input  logic              reset,
    mesm6_gpio2_if.slave      gpio,
    output logic              interrupt,
    input  logic [WIDTH-1:0]  gpio_inputs,
    output logic [WIDTH-1:0]  gpio_outputs,
    output logic [WIDTH-1:0]  gpio_oe
);
    logic [WIDTH-1:0]  dir, port, ien, irise, ifall, iflag;
    logic [WIDTH-1:0]  val, val_prev, edges, wd, iflag_clr, iflag_next;
    logic              gie;
    logic [3:0]        reg_sel;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              unused_bits;

    assign reg_sel     = gpio.gpio_addr[3:0];
    assign wd          = gpio.gpio_wdata[WIDTH-1:0];
    assign unused_bits = ^{gpio.gpio_addr[ADDR_W-1:4], gpio.gpio_wdata};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pin
            mesm6_gpio2_filter #(.DEBOUNCE(DEBOUNCE)) u_filter (
                .clk   (clk),
                .reset (reset),
                .pin   (gpio_inputs[i]),
                .val   (val[i])
            );
        end
    endgenerate

    assign edges      = (val & ~val_prev & irise) | (~val & val_prev & ifall);
    assign iflag_clr  = (gpio.gpio_write && reg_sel == ADDR_IFLAG) ? wd : '0;
    // A new edge beats a simultaneous W1C so no event is lost.
    assign iflag_next = (iflag & ~iflag_clr) | edges;

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            ADDR_DIR:                     rd_mux[WIDTH-1:0] = dir;
            ADDR_PORT, ADDR_SET,
            ADDR_CLR, ADDR_TGL:           rd_mux[WIDTH-1:0] = port;
            ADDR_VAL:                     rd_mux[WIDTH-1:0] = val;
            ADDR_IEN:                     rd_mux[WIDTH-1:0] = ien;
            ADDR_IRISE:                   rd_mux[WIDTH-1:0] = irise;
            ADDR_IFALL:                   rd_mux[WIDTH-1:0] = ifall;
            ADDR_IFLAG:                   rd_mux[WIDTH-1:0] = iflag;
            ADDR_CTRL:                    rd_mux[CTRL_GIE]  = gie;
            default:                      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir      <= '0;
            port     <= '0;
            ien      <= '0;
            irise    <= '0;
            ifall    <= '0;
            iflag    <= '0;
            gie      <= 1'b0;
            val_prev <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            val_prev <= val;
            iflag    <= iflag_next;
            done_q   <= gpio.gpio_read | gpio.gpio_write;
            if (gpio.gpio_read) rdata_q <= rd_mux;
            if (gpio.gpio_write) begin
                case (reg_sel)
                    ADDR_DIR:   dir   <= wd;
                    ADDR_PORT:  port  <= wd;
                    ADDR_SET:   port  <= port | wd;
                    ADDR_CLR:   port  <= port & ~wd;
                    ADDR_TGL:   port  <= port ^ wd;
                    ADDR_IEN:   ien   <= wd;
                    ADDR_IRISE: irise <= wd;
                    ADDR_IFALL: ifall <= wd;
                    ADDR_CTRL:  gie   <= wd[CTRL_GIE];
                    default:    ;
                endcase
            end
        end
    end

    assign gpio.gpio_rdata = rdata_q;
    assign gpio.gpio_done  = done_q;
    assign gpio_outputs    = port;
    assign gpio_oe         = dir;
    assign interrupt       = gie & |(iflag & ien);
endmodule

// File: tb/tb_mesm6_gpio2.sv
// Bench for mesm6_gpio2: one unfiltered 48-pin instance and one debounced
// 8-pin instance, directed register traffic with a read-data scoreboard.
module tb_mesm6_gpio2;
    import mesm6_gpio2_pkg::*;

    logic        clk;
    logic        reset;
    logic [47:0] pads0, outs0, oe0;
    logic [7:0]  pads1, outs1, oe1;
    logic        irq0, irq1;
    int          checks = 0;
    int          errors = 0;

    // Entry: [52] compare rdata, [51:48] register address, [47:0] expected data
    logic [52:0] exp_q0[$];
    logic [52:0] exp_q1[$];

    mesm6_gpio2_if bus0();
    mesm6_gpio2_if bus1();

    mesm6_gpio2 #(.WIDTH(48), .DEBOUNCE(0)) dut0 (
        .clk(clk), .reset(reset), .gpio(bus0), .interrupt(irq0),
        .gpio_inputs(pads0), .gpio_outputs(outs0), .gpio_oe(oe0)
    );

    mesm6_gpio2 #(.WIDTH(8), .DEBOUNCE(4)) dut1 (
        .clk(clk), .reset(reset), .gpio(bus1), .interrupt(irq1),
        .gpio_inputs(pads1), .gpio_outputs(outs1), .gpio_oe(oe1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // drivers
    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [14:0] a, input logic [47:0] wd);
        if (sel == 0) begin
            bus0.gpio_read = rd; bus0.gpio_write = wr;
            bus0.gpio_addr = a;  bus0.gpio_wdata = wd;
        end else begin
            bus1.gpio_read = rd; bus1.gpio_write = wr;
            bus1.gpio_addr = a;  bus1.gpio_wdata = wd;
        end
    endtask

    function automatic logic done_of(input int sel);
        return (sel == 0) ? bus0.gpio_done : bus1.gpio_done;
    endfunction

    // Called at a falling edge; returns at a falling edge two cycles later.
    task automatic bus_op(input int sel, input logic rd, input logic wr,
                          input logic [14:0] a, input logic [47:0] wd,
                          input logic [47:0] exp);
        logic [52:0] e;
        e = {rd, a[3:0], exp};
        drive(sel, rd, wr, a, wd);
        if (sel == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 15'd0, 48'd0);
        check("done_pulse", {47'd0, done_of(sel)}, 48'd1);
        @(negedge clk);
        check("done_width", {47'd0, done_of(sel)}, 48'd0);
    endtask

    task automatic wr(input int sel, input logic [3:0] a, input logic [47:0] d);
        bus_op(sel, 1'b0, 1'b1, {11'd0, a}, d, 48'd0);
    endtask

    task automatic rd(input int sel, input logic [3:0] a, input logic [47:0] exp);
        bus_op(sel, 1'b1, 1'b0, {11'd0, a}, 48'd0, exp);
    endtask

    // scoreboard monitor
    task automatic mon_step(input int sel, input logic [47:0] rdata);
        logic [52:0] e;
        if ((sel == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done bus%0d rdata=%h expected no done", sel, rdata);
        end else begin
            e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (e[52]) begin
                checks++;
                if (rdata !== e[47:0]) begin
                    errors++;
                    $display("FAIL rdata bus%0d addr=%0d actual=%h expected=%h",
                             sel, e[51:48], rdata, e[47:0]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus0.gpio_done) mon_step(0, bus0.gpio_rdata);
        if (bus1.gpio_done) mon_step(1, bus1.gpio_rdata);
    end

    initial begin
        reset = 1'b1;
        pads0 = '0;
        pads1 = '0;
        drive(0, 1'b0, 1'b0, 15'd0, 48'd0);
        drive(1, 1'b0, 1'b0, 15'd0, 48'd0);
        repeat (3) @(negedge clk);
        check("rst_done",  {47'd0, bus0.gpio_done}, 48'd0);
        check("rst_rdata", bus0.gpio_rdata, 48'd0);
        check("rst_irq",   {47'd0, irq0}, 48'd0);
        check("rst_outs",  outs0, 48'd0);
        check("rst_oe",    oe0, 48'd0);
        reset = 1'b0;

        // port set/clear/toggle
        wr(0, ADDR_DIR, 48'hff);          check("oe_dir", oe0, 48'hff);
        wr(0, ADDR_PORT, 48'o17);         check("port_wr", outs0, 48'o17);
        wr(0, ADDR_SET, 48'o60);          check("port_set", outs0, 48'o77);
        wr(0, ADDR_CLR, 48'o1);           check("port_clr", outs0, 48'o76);
        wr(0, ADDR_TGL, 48'o100);         check("port_tgl", outs0, 48'o176);
        rd(0, ADDR_PORT, 48'o176);
        rd(0, ADDR_SET, 48'o176);
        rd(0, ADDR_TGL, 48'o176);
        bus_op(0, 1'b1, 1'b1, {11'd0, ADDR_PORT}, 48'h5, 48'o176);
        check("rw_same_cycle", outs0, 48'h5);
        rd(0, 4'd11, 48'd0);
        wr(0, 4'd13, 48'hffff);
        bus_op(0, 1'b1, 1'b0, 15'h7ff1, 48'd0, 48'h5);
        rd(0, ADDR_DIR, 48'hff);

        // rising edge on pin0, no filter
        wr(0, ADDR_IRISE, 48'h1);
        wr(0, ADDR_IEN, 48'h1);
        wr(0, ADDR_CTRL, 48'h1);
        check("irq_idle", {47'd0, irq0}, 48'd0);
        pads0[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("val_lat2", {47'd0, dut0.val[0]}, 48'd0);
        @(negedge clk);
        check("val_lat3", {47'd0, dut0.val[0]}, 48'd1);
        check("irq_lat3", {47'd0, irq0}, 48'd0);
        @(negedge clk);
        check("irq_lat4", {47'd0, irq0}, 48'd1);
        rd(0, ADDR_VAL, 48'h1);
        rd(0, ADDR_IFLAG, 48'h1);

        // falling edge on pin1 and W1C
        wr(0, ADDR_IFLAG, 48'h1);
        check("irq_w1c0", {47'd0, irq0}, 48'd0);
        rd(0, ADDR_IFLAG, 48'h0);
        wr(0, ADDR_IFALL, 48'h2);
        wr(0, ADDR_IEN, 48'h3);
        pads0[1] = 1'b1;
        repeat (5) @(negedge clk);
        rd(0, ADDR_IFLAG, 48'h0);
        pads0[1] = 1'b0;
        repeat (5) @(negedge clk);
        rd(0, ADDR_IFLAG, 48'h2);
        check("irq_fall", {47'd0, irq0}, 48'd1);
        rd(0, ADDR_VAL, 48'h1);
        wr(0, ADDR_IFLAG, 48'h2);
        check("irq_w1c1", {47'd0, irq0}, 48'd0);
        rd(0, ADDR_IFLAG, 48'h0);

        // W1C colliding with a new rising edge on pin0
        pads0[0] = 1'b0;
        repeat (5) @(negedge clk);
        pads0[0] = 1'b1;
        repeat (5) @(negedge clk);
        rd(0, ADDR_IFLAG, 48'h1);
        pads0[0] = 1'b0;
        repeat (5) @(negedge clk);
        pads0[0] = 1'b1;
        repeat (3) @(negedge clk);
        wr(0, ADDR_IFLAG, 48'h1);
        rd(0, ADDR_IFLAG, 48'h1);
        check("irq_collide", {47'd0, irq0}, 48'd1);

        // global enable gates the level interrupt
        wr(0, ADDR_CTRL, 48'h0);
        check("irq_gie0", {47'd0, irq0}, 48'd0);
        rd(0, ADDR_CTRL, 48'h0);
        wr(0, ADDR_CTRL, 48'h1);
        check("irq_gie1", {47'd0, irq0}, 48'd1);
        rd(0, ADDR_CTRL, 48'h1);

        // narrow, debounced instance
        wr(1, ADDR_PORT, 48'hffff_ffff_ffff);
        check("w8_outs", {40'd0, outs1}, 48'hff);
        rd(1, ADDR_PORT, 48'hff);
        rd(1, ADDR_VAL, 48'h0);
        pads1[2] = 1'b1;
        repeat (3) @(negedge clk);
        pads1[2] = 1'b0;
        repeat (8) @(negedge clk);
        rd(1, ADDR_VAL, 48'h0);
        pads1[2] = 1'b1;
        repeat (5) @(negedge clk);
        check("deb_lat5", {47'd0, dut1.val[2]}, 48'd0);
        @(negedge clk);
        check("deb_lat6", {47'd0, dut1.val[2]}, 48'd1);
        rd(1, ADDR_VAL, 48'h4);

        // reset during a read+write request
        pads0 = '0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, {11'd0, ADDR_PORT}, 48'hff);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 15'd0, 48'd0);
        check("rst_abort_done", {47'd0, bus0.gpio_done}, 48'd0);
        @(negedge clk);
        check("rst_abort_done2", {47'd0, bus0.gpio_done}, 48'd0);
        reset = 1'b0;
        check("rst2_irq",   {47'd0, irq0}, 48'd0);
        check("rst2_outs",  outs0, 48'd0);
        check("rst2_oe",    oe0, 48'd0);
        check("rst2_rdata", bus0.gpio_rdata, 48'd0);
        rd(0, 4'd12, 48'd0);
        rd(0, ADDR_DIR, 48'd0);
        rd(0, ADDR_PORT, 48'd0);
        rd(0, ADDR_IEN, 48'd0);
        rd(0, ADDR_IRISE, 48'd0);
        rd(0, ADDR_IFALL, 48'd0);
        rd(0, ADDR_IFLAG, 48'd0);
        rd(0, ADDR_CTRL, 48'd0);
        rd(0, ADDR_VAL, 48'd0);

        // final report
        repeat (3) @(negedge clk);
        check("q0_drained", 48'(exp_q0.size()), 48'd0);
        check("q1_drained", 48'(exp_q1.size()), 48'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mesm6_gpio2.md
MESM6_GPIO2 -- requirements
Module: mesm6_gpio2

Interface
REQ-001 SHALL have parameter WIDTH, default 48, number of GPIO pins (1..48); unused upper data bits read 0.
REQ-002 SHALL have parameter DEBOUNCE, default 0, consecutive stable cycles required before VAL updates; 0 bypasses the filter.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port interrupt  output  1  interrupt request to CPU.
REQ-006 SHALL have port gpio_addr  input  15  register address; only bits [3:0] decoded.
REQ-007 SHALL have port gpio_read  input  1  read request.
REQ-008 SHALL have port gpio_write  input  1  write request.
REQ-009 SHALL have port gpio_rdata  output  48  registered read data.
REQ-010 SHALL have port gpio_wdata  input  48  write data.
REQ-011 SHALL have port gpio_done  output  1  operation complete pulse.
REQ-012 SHALL have port gpio_inputs  input  WIDTH  asynchronous pad inputs.
REQ-013 SHALL have port gpio_outputs  output  WIDTH  pad output values, equal to PORT.
REQ-014 SHALL have port gpio_oe  output  WIDTH  pad output enables, equal to DIR.

Function
REQ-015 SHALL decode addr[3:0]: 0 DIR rw (1=output); 1 PORT rw; 2 SET w; 3 CLR w; 4 TGL w; 5 VAL ro; 6 IEN rw; 7 IRISE rw; 8 IFALL rw; 9 IFLAG r/W1C; 10 CTRL rw (bit0 GIE); 11-15 read 0, writes ignored.
REQ-016 SHALL apply a write in the cycle gpio_write is high: SET gives PORT|=wdata, CLR gives PORT&=~wdata, TGL gives PORT^=wdata.
REQ-017 SHALL return PORT when SET, CLR or TGL is read.
REQ-018 SHALL assert gpio_done for exactly one cycle, one cycle after any cycle with gpio_read or gpio_write high, including unmapped addresses.
REQ-019 SHALL load gpio_rdata on a read cycle, valid while gpio_done is high, and hold it otherwise.
REQ-020 SHALL perform both actions when read and write occur in the same cycle, with gpio_rdata returning the pre-write value.
REQ-021 SHALL synchronise each input through two flops.
REQ-022 SHALL, per pin, reload a counter to 0 when the synchronised value equals VAL, otherwise increment it, and update VAL when the count reaches DEBOUNCE-1.
REQ-023 SHALL, with DEBOUNCE=0, update VAL exactly 3 cycles after a pad change.
REQ-024 SHALL have VAL track the pad regardless of DIR.
REQ-025 SHALL set IFLAG[i] in the cycle after VAL[i] rises while IRISE[i]=1, or falls while IFALL[i]=1, independent of IEN.
REQ-026 SHALL keep IFLAG set when a W1C clear and a new edge hit the same bit in the same cycle (set wins).
REQ-027 SHALL drive interrupt = GIE & |(IFLAG & IEN) combinationally from registers.
REQ-028 SHALL keep interrupt asserted until the relevant flags are cleared, IEN is masked or GIE=0 (level, sticky).
REQ-029 SHALL ignore gpio_wdata bits at and above WIDTH.

Reset
REQ-030 SHALL clear DIR, PORT, IEN, IRISE, IFALL, IFLAG, GIE, VAL, sync flops, debounce counters, gpio_rdata and gpio_done to 0 on reset.
REQ-031 SHALL abort a request issued during reset without a done pulse.
REQ-032 SHALL take reset priority over any concurrent write.

Structure
REQ-033 SHALL place register address constants and the CTRL bit index in package mesm6_gpio2_pkg.
REQ-034 SHALL implement per-pin sync and debounce in sub-module mesm6_gpio2_filter, instantiated WIDTH times via generate.

Verification
REQ-035 SHALL verify: write PORT=0o17, SET 0o60, CLR 0o1, TGL 0o100 -> PORT=0o176, gpio_outputs matches, done pulses 1 cycle after each write.
REQ-036 SHALL verify: DEBOUNCE=0, IRISE=1, IEN=1, GIE=1, pin0 0->1 -> VAL[0]=1 after 3 cycles, IFLAG[0] and interrupt 1 cycle later.
REQ-037 SHALL verify: IFALL=0b10, pin1 falls -> IFLAG=0b10; write IFLAG 0b10 -> IFLAG 0, interrupt deasserts next cycle.
REQ-038 SHALL verify: DEBOUNCE=4, 3-cycle glitch on pin2 -> VAL unchanged; 4-cycle stable high -> VAL[2]=1.
REQ-039 SHALL verify: W1C to IFLAG[0] in same cycle as new rising edge on pin0 -> IFLAG[0] stays 1.
REQ-040 SHALL verify: reset asserted mid-read -> no gpio_done, all registers and interrupt 0, read of address 12 returns 0.
